// File: rtl/seq_div_8by4_pkg.sv
// div_pkg: shared widths, FSM states and divide-by-zero constant for seq_div_8by4
package div_pkg;
    localparam int DW = 8;
    localparam int VW = 4;
    localparam logic [DW-1:0] DZ_QUOT = 8'hFF;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
endpackage

// File: rtl/seq_div_8by4_if.sv
// seq_div_8by4_if: operand and result valid/ready channels of the sequential divider
interface seq_div_8by4_if #(parameter int DW = 8, parameter int VW = 4);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dz;
    logic          chk_err;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dz, chk_err
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dz, chk_err
    );
endinterface

// File: rtl/seq_div_8by4_step.sv
// div_step: one combinational restoring iteration on the shifted partial remainder
module div_step #(parameter int VW = 4) (
    input  logic [VW:0]   r_sh,
    input  logic [VW-1:0] dvs,
    output logic [VW-1:0] r_nxt,
    output logic          qbit
);
    assign qbit  = r_sh >= {1'b0, dvs};
    assign r_nxt = qbit ? VW'(r_sh - {1'b0, dvs}) : r_sh[VW-1:0];
endmodule

// File: rtl/seq_div_8by4.sv
// seq_div_8by4: iterative unsigned restoring divider, one quotient bit per clock.
// Defining SEQ_DIV_SELFCHECK_EN adds a q*d+r==dividend result check on chk_err.
module seq_div_8by4 #(parameter int DW = 8, parameter int VW = 4) (
    input  logic           clk,
    input  logic           rst,
    seq_div_8by4_if.slave  bus
);
    import div_pkg::*;
    localparam int CW = $clog2(DW);
    div_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd, q, q_nxt;
    logic [VW-1:0] dvs, r, r_nxt;
    logic          qbit, dz, chk_err, chk_nxt, accept, zdiv;
    assign accept = bus.in_valid && state == IDLE;
    assign zdiv   = bus.divisor == '0;
    div_step #(.VW(VW)) u_step (.r_sh({r, dvd[cnt]}), .dvs(dvs), .r_nxt(r_nxt), .qbit(qbit));
    assign q_nxt = q | (DW'(qbit) << cnt);
`ifdef SEQ_DIV_SELFCHECK_EN
    logic [DW+VW-1:0] recon;
    assign recon   = (DW+VW)'(q_nxt) * (DW+VW)'(dvs) + (DW+VW)'(r_nxt);
    assign chk_nxt = recon != (DW+VW)'(dvd) || r_nxt >= dvs;
`else
    assign chk_nxt = 1'b0;
`endif
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
        if (accept)
            state_nxt = zdiv ? DONE : BUSY;
        else if (state == BUSY && cnt == '0)
            state_nxt = DONE;
        else if (state == DONE && bus.out_ready)
            state_nxt = IDLE;
    end
    // Results are only written on accept and in BUSY, so they hold through a DONE stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= CW'(DW-1);
            dvd     <= '0;
            dvs     <= '0;
            q       <= '0;
            r       <= '0;
            dz      <= 1'b0;
            chk_err <= 1'b0;
        end else if (accept) begin
            cnt     <= CW'(DW-1);
            dvd     <= bus.dividend;
            dvs     <= bus.divisor;
            q       <= zdiv ? DW'(DZ_QUOT) : '0;
            r       <= zdiv ? bus.dividend[VW-1:0] : '0;
            dz      <= zdiv;
            chk_err <= 1'b0;
        end else if (state == BUSY) begin
            cnt <= cnt - 1'b1;
            q   <= q_nxt;
            r   <= r_nxt;
            if (cnt == '0)
                chk_err <= chk_nxt;
        end
    end
    assign bus.quotient  = q;
    assign bus.remainder = r;
    assign bus.dz        = dz;
    assign bus.chk_err   = chk_err;
endmodule

// File: tb/tb_seq_div_8by4.sv
// tb_seq_div_8by4: directed and randomized checks of seq_div_8by4 handshake, latency and results
module tb_seq_div_8by4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    seq_div_8by4_if bus();
    seq_div_8by4 dut (.clk(clk), .rst(rst), .bus(bus));
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] q_o;
    logic [3:0] r_o;
    logic dz_o, ce_o, ir_o;
    int lat;

    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit toggle);
        int w = 0;
        while (!bus.in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        ir_o = bus.in_ready;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 30) begin
            if (toggle) begin
                bus.dividend = 8'($urandom);
                bus.divisor  = 4'($urandom);
                bus.in_valid = 1'($urandom);
            end
            @(posedge clk); #1; lat++;
        end
        bus.in_valid = 1'b0;
        q_o  = bus.quotient;
        r_o  = bus.remainder;
        dz_o = bus.dz;
        ce_o = bus.chk_err;
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] got;
        repeat (3) @(posedge clk);
        #1;
        got = {bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.dz, bus.chk_err};
        n_cmp++;
        if (got !== 16'h8000) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", got, 16'h8000);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_op(8'd225, 4'd15, 1'b0);
        n_cmp++;
        if (ir_o !== 1'b0) begin
            n_err++;
            $display("FAIL basic_in_ready_drop: got %b want 0", ir_o);
        end
        n_cmp++;
        if (lat != 9) begin
            n_err++;
            $display("FAIL basic_latency: got %0d want 9", lat);
        end
        n_cmp++;
        if ({q_o, r_o, dz_o, ce_o} !== {8'd15, 4'd0, 2'b00}) begin
            n_err++;
            $display("FAIL basic_225_15: got q=%0d r=%0d dz=%b ce=%b want q=15 r=0 dz=0 ce=0", q_o, r_o, dz_o, ce_o);
        end
        handoff();
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL basic_after_handoff: got ir/ov=%b%b want 10", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_stall();
        run_op(8'd200, 4'd7, 1'b0);
        n_cmp++;
        if (lat != 9) begin
            n_err++;
            $display("FAIL stall_latency: got %0d want 9", lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({bus.out_valid, bus.quotient, bus.remainder, bus.dz} !== {1'b1, 8'd28, 4'd4, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold%0d: got ov=%b q=%0d r=%0d dz=%b want ov=1 q=28 r=4 dz=0",
                         i, bus.out_valid, bus.quotient, bus.remainder, bus.dz);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_no_same_cycle_accept: got in_ready=%b want 0", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL stall_in_ready_return: got ir/ov=%b%b want 10", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_div_zero();
        run_op(8'd37, 4'd0, 1'b0);
        n_cmp++;
        if (lat != 1) begin
            n_err++;
            $display("FAIL dz_latency: got %0d want 1", lat);
        end
        n_cmp++;
        if ({q_o, r_o, dz_o, ce_o} !== {8'hFF, 4'd5, 2'b10}) begin
            n_err++;
            $display("FAIL dz_37_0: got q=%h r=%0d dz=%b ce=%b want q=ff r=5 dz=1 ce=0", q_o, r_o, dz_o, ce_o);
        end
        handoff();
    endtask

    task automatic test_boundaries();
        logic [7:0] va [4] = '{8'd5, 8'd255, 8'd0, 8'd255};
        logic [3:0] vb [4] = '{4'd9, 4'd1, 4'd3, 4'd15};
        logic [7:0] vq [4] = '{8'd0, 8'd255, 8'd0, 8'd17};
        logic [3:0] vr [4] = '{4'd5, 4'd0, 4'd0, 4'd0};
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], 1'b0);
            n_cmp++;
            if (lat != 9) begin
                n_err++;
                $display("FAIL bound%0d_latency: got %0d want 9", i, lat);
            end
            n_cmp++;
            if ({q_o, r_o, dz_o, ce_o} !== {vq[i], vr[i], 2'b00}) begin
                n_err++;
                $display("FAIL bound%0d_%0d_%0d: got q=%0d r=%0d dz=%b ce=%b want q=%0d r=%0d",
                         i, va[i], vb[i], q_o, r_o, dz_o, ce_o, vq[i], vr[i]);
            end
            handoff();
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        bit seen = 1'b0;
        bus.dividend = 8'd100;
        bus.divisor  = 4'd3;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        got = {bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.dz, bus.chk_err};
        n_cmp++;
        if (got !== 16'h8000) begin
            n_err++;
            $display("FAIL midrst_state: got %h want %h", got, 16'h8000);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen |= bus.out_valid;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_no_out_valid: got out_valid seen=%b want 0", seen);
        end
        run_op(8'd100, 4'd3, 1'b0);
        n_cmp++;
        if ({q_o, r_o, dz_o, lat} !== {8'd33, 4'd1, 1'b0, 9}) begin
            n_err++;
            $display("FAIL midrst_rerun_100_3: got q=%0d r=%0d dz=%b lat=%0d want q=33 r=1 dz=0 lat=9", q_o, r_o, dz_o, lat);
        end
        handoff();
    endtask

    task automatic test_operand_toggle();
        run_op(8'd150, 4'd11, 1'b1);
        n_cmp++;
        if ({q_o, r_o, dz_o, ce_o, lat} !== {8'd13, 4'd7, 2'b00, 9}) begin
            n_err++;
            $display("FAIL toggle_150_11: got q=%0d r=%0d dz=%b ce=%b lat=%0d want q=13 r=7 lat=9", q_o, r_o, dz_o, ce_o, lat);
        end
        handoff();
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, eq;
        logic [3:0] b, er;
        int el;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 4'($urandom);
            eq = (b == 0) ? 8'hFF : a / {4'd0, b};
            er = (b == 0) ? a[3:0] : 4'(a % {4'd0, b});
            el = (b == 0) ? 1 : 9;
            run_op(a, b, 1'b0);
            n_cmp++;
            if ({q_o, r_o, dz_o, ce_o} !== {eq, er, b == 0, 1'b0} || lat != el) begin
                n_err++;
                $display("FAIL b2b%0d_%0d_%0d: got q=%0d r=%0d dz=%b ce=%b lat=%0d want q=%0d r=%0d dz=%b ce=0 lat=%0d",
                         i, a, b, q_o, r_o, dz_o, ce_o, lat, eq, er, b == 0, el);
            end
            handoff();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        test_reset();
        test_basic();
        test_stall();
        test_div_zero();
        test_boundaries();
        test_reset_mid();
        test_operand_toggle();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
